// File: rtl/id_issue_stage.sv
// Decode-side issue stage: holds one decoded instruction, resolves its two
// source operands (register file, writeback bypass or wait) and issues to EX.
module id_issue_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int OP_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    output logic [REG_W-1:0]  rf_rs1,
    input  logic [DATA_W-1:0] rf_src1,
    input  logic              rf_modi1,
    output logic [REG_W-1:0]  rf_rs2,
    input  logic [DATA_W-1:0] rf_src2,
    input  logic              rf_modi2,
    output logic [REG_W-1:0]  rf_rd,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [REG_W-1:0]  out_rd,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [OP_W-1:0]   r_op;
    logic [REG_W-1:0]  r_rs1;
    logic [REG_W-1:0]  r_rs2;
    logic [REG_W-1:0]  r_rd;
    logic              r_got1;
    logic              r_got2;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_accept;
    logic              w_fire;
    logic              w_res1;
    logic              w_res2;
    logic              w_both;
    logic [DATA_W-1:0] w_val1;
    logic [DATA_W-1:0] w_val2;

    // Handshakes: a transfer happens on a cycle where valid & ready are both
    // high; valid never depends on ready, and flush or rst cancel either side.
    assign in_ready = ~flush & ((r_state == ST_EMPTY) |
                                ((r_state == ST_ISSUE) & out_ready));
    assign w_accept = in_valid & in_ready;
    assign w_fire   = (r_state == ST_ISSUE) & out_ready & ~flush & ~rst;
    assign rf_rd    = w_fire ? r_rd : '0;

    // Operand priority: x0 reads as zero, then same-cycle writeback, then file.
    always_comb begin
        w_val1 = rf_src1;
        w_res1 = r_got1 | ~rf_modi1;
        if (r_rs1 == '0) begin
            w_val1 = '0;
            w_res1 = 1'b1;
        end else if (wb_reg == r_rs1) begin
            w_val1 = wb_data;
            w_res1 = 1'b1;
        end
        w_val2 = rf_src2;
        w_res2 = r_got2 | ~rf_modi2;
        if (r_rs2 == '0) begin
            w_val2 = '0;
            w_res2 = 1'b1;
        end else if (wb_reg == r_rs2) begin
            w_val2 = wb_data;
            w_res2 = 1'b1;
        end
        w_both = w_res1 & w_res2;
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_next_state = ST_WAIT;
                ST_WAIT:  if (w_both)   w_next_state = ST_ISSUE;
                ST_ISSUE: if (w_fire)   w_next_state = w_accept ? ST_WAIT : ST_EMPTY;
                default:  w_next_state = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_op        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_got1      <= 1'b0;
            r_got2      <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op   <= in_op;
                r_rs1  <= in_rs1;
                r_rs2  <= in_rs2;
                r_rd   <= in_rd;
                r_got1 <= 1'b0;
                r_got2 <= 1'b0;
            end else if (w_next_state == ST_EMPTY) begin
                r_rs1 <= '0;
                r_rs2 <= '0;
            end
            // A flushed WAIT cycle captures nothing and is not counted as a stall.
            if ((r_state == ST_WAIT) && !flush) begin
                if (!r_got1 && w_res1) begin
                    r_op1  <= w_val1;
                    r_got1 <= 1'b1;
                end
                if (!r_got2 && w_res2) begin
                    r_op2  <= w_val2;
                    r_got2 <= 1'b1;
                end
                if (!w_both && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end
        end
    end

    assign rf_rs1    = r_rs1;
    assign rf_rs2    = r_rs2;
    assign out_valid = (r_state == ST_ISSUE);
    assign out_op    = r_op;
    assign out_rd    = r_rd;
    assign out_op1   = r_op1;
    assign out_op2   = r_op2;
    assign stall_cnt = r_stall_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: plays the register file, drives directed and
// randomized instructions, and checks issued operands against a queue model.
module tb_id_issue_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 8;
    localparam int CNT_W  = 16;
    localparam int EXP_W  = OP_W + REG_W + 2 * DATA_W;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [OP_W-1:0]   in_op, out_op;
    logic [REG_W-1:0]  in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2, rf_rd, wb_reg, out_rd;
    logic [DATA_W-1:0] rf_src1, rf_src2, wb_data, out_op1, out_op2;
    logic              rf_modi1, rf_modi2;
    logic [CNT_W-1:0]  stall_cnt;
    logic [1:0]        dbg_state;

    // Register file model: values and pending flags, read combinationally.
    logic [DATA_W-1:0] rf_val [32];
    logic              rf_mod [32];
    assign rf_src1  = rf_val[rf_rs1];
    assign rf_modi1 = rf_mod[rf_rs1];
    assign rf_src2  = rf_val[rf_rs2];
    assign rf_modi2 = rf_mod[rf_rs2];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int stall_exp = 0;
    logic [EXP_W-1:0] exp_q [$];

    logic [OP_W-1:0]   cur_op;
    logic [REG_W-1:0]  cur_rs1, cur_rs2, cur_rd;
    int                cur_d1, cur_d2;
    logic [DATA_W-1:0] cur_wv1, cur_wv2;

    id_issue_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .rf_rs1(rf_rs1), .rf_src1(rf_src1), .rf_modi1(rf_modi1),
        .rf_rs2(rf_rs2), .rf_src2(rf_src2), .rf_modi2(rf_modi2),
        .rf_rd(rf_rd), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rd(out_rd), .out_op1(out_op1), .out_op2(out_op2),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // d1/d2: -1 = register not pending, else the WAIT cycle index carrying its writeback.
    task automatic prep(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rs1,
                        input logic [REG_W-1:0] rs2, input logic [REG_W-1:0] rd,
                        input logic [DATA_W-1:0] rv1, input logic [DATA_W-1:0] rv2,
                        input int d1, input int d2,
                        input logic [DATA_W-1:0] wv1, input logic [DATA_W-1:0] wv2);
        logic [DATA_W-1:0] e1, e2;
        if (rs1 == 0) d1 = -1;
        if (rs2 == 0) d2 = -1;
        if (rs2 == rs1) begin
            d2 = d1; rv2 = rv1; wv2 = wv1;
        end else if (d1 >= 0 && d1 == d2) begin
            d2 = d1 + 1;
        end
        if (rs1 != 0) begin rf_val[rs1] = rv1; rf_mod[rs1] = (d1 >= 0); end
        if (rs2 != 0) begin rf_val[rs2] = rv2; rf_mod[rs2] = (d2 >= 0); end
        e1 = (rs1 == 0) ? '0 : ((d1 >= 0) ? wv1 : rv1);
        e2 = (rs2 == 0) ? '0 : ((d2 >= 0) ? wv2 : rv2);
        stall_exp += max3(d1, d2, 0);
        exp_q.push_back({op, rd, e1, e2});
        cur_op = op; cur_rs1 = rs1; cur_rs2 = rs2; cur_rd = rd;
        cur_d1 = d1; cur_d2 = d2; cur_wv1 = wv1; cur_wv2 = wv2;
    endtask

    task automatic do_accept();
        int n;
        n = 0;
        in_valid = 1'b1; in_op = cur_op; in_rs1 = cur_rs1; in_rs2 = cur_rs2; in_rd = cur_rd;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    endtask

    task automatic wait_phase();
        int last;
        last = max3(cur_d1, cur_d2, 0);
        for (int c = 0; c <= last; c++) begin
            wb_reg = '0;
            wb_data = $urandom;
            if (cur_d1 == c) begin
                wb_reg = cur_rs1; wb_data = cur_wv1;
            end else if (cur_d2 == c) begin
                wb_reg = cur_rs2; wb_data = cur_wv2;
            end
            #1;
            chk("wait_out_valid", out_valid, 0);
            if (c == 0) begin
                chk("wait_rf_rs1", rf_rs1, cur_rs1);
                chk("wait_rf_rs2", rf_rs2, cur_rs2);
                chk("wait_in_ready", in_ready, 0);
            end
            tick();
        end
        wb_reg = '0;
        chk("issue_out_valid", out_valid, 1);
        chk("stall_cnt", stall_cnt, stall_exp);
    endtask

    task automatic chk_out(input logic [EXP_W-1:0] e);
        chk("out_op",  out_op,  e[EXP_W-1 -: OP_W]);
        chk("out_rd",  out_rd,  e[2*DATA_W +: REG_W]);
        chk("out_op1", out_op1, e[DATA_W +: DATA_W]);
        chk("out_op2", out_op2, e[0 +: DATA_W]);
    endtask

    task automatic fire_phase(input int h);
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        out_ready = 1'b0;
        for (int i = 0; i < h; i++) begin
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_rf_rd", rf_rd, 0);
            chk("hold_in_ready", in_ready, 0);
            chk_out(e);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk_out(e);
        chk("fire_rf_rd", rf_rd, cur_rd);
        chk("fire_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b0;
        #1;
        chk("post_fire_out_valid", out_valid, 0);
        chk("post_fire_rf_rd", rf_rd, 0);
    endtask

    initial begin
        logic [EXP_W-1:0] e;
        logic [REG_W-1:0] rd_a;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; wb_reg = '0; wb_data = '0;
        for (int r = 0; r < 32; r++) begin
            rf_val[r] = $urandom;
            rf_mod[r] = 1'b0;
        end
        // Register 0 looks pending and nonzero; it must still read as zero.
        rf_val[0] = 32'hDEAD_BEEF;
        rf_mod[0] = 1'b1;

        // Reset
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_rf_rs1", rf_rs1, 0);

        // Both operands ready: one-cycle latency
        prep(8'hA1, 5'd3, 5'd4, 5'd7, 32'd30, 32'd40, -1, -1, '0, '0);
        do_accept(); wait_phase(); fire_phase(0);

        // Pending rs1 resolved by bypass after 4 stall cycles, then 5-cycle backpressure
        prep(8'hB2, 5'd5, 5'd0, 5'd6, 32'h1234, 32'h0, 4, -1, 32'h55, '0);
        do_accept(); wait_phase(); fire_phase(5);

        // Back-to-back: fire A while accepting B which reads A's rd
        prep(8'hC3, 5'd1, 5'd2, 5'd7, 32'h11, 32'h22, -1, -1, '0, '0);
        do_accept(); wait_phase();
        e = exp_q.pop_front();
        rd_a = cur_rd;
        prep(8'hD4, 5'd7, 5'd0, 5'd8, 32'h0, 32'h0, 2, -1, 32'h77, '0);
        in_valid = 1'b1; in_op = cur_op; in_rs1 = cur_rs1; in_rs2 = cur_rs2; in_rd = cur_rd;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        chk("b2b_rf_rd", rf_rd, rd_a);
        chk_out(e);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        wait_phase(); fire_phase(1);

        // Flush while waiting on a pending operand
        prep(8'hE5, 5'd9, 5'd10, 5'd11, 32'h9, 32'hA, 3, -1, 32'h99, '0);
        void'(exp_q.pop_back());
        stall_exp -= 3;
        do_accept();
        tick();
        stall_exp += 1;
        flush = 1'b1;
        #1;
        chk("flush_wait_in_ready", in_ready, 0);
        chk("flush_wait_rf_rd", rf_rd, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_wait_out_valid", out_valid, 0);
        chk("flush_wait_in_ready_after", in_ready, 1);
        chk("flush_wait_rf_rs1", rf_rs1, 0);
        chk("flush_wait_stall", stall_cnt, stall_exp);

        // Flush on a would-be fire cycle, with a competing input offered
        prep(8'hF6, 5'd12, 5'd13, 5'd14, 32'hC, 32'hD, -1, -1, '0, '0);
        do_accept(); wait_phase();
        void'(exp_q.pop_front());
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_rs1 = 5'd20; in_rs2 = 5'd21; in_rd = 5'd22;
        #1;
        chk("flush_fire_rf_rd", rf_rd, 0);
        chk("flush_fire_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_fire_out_valid", out_valid, 0);
        chk("flush_fire_in_ready_after", in_ready, 1);
        chk("flush_fire_rf_rs1", rf_rs1, 0);
        tick();
        chk("flush_fire_rf_rd_after", rf_rd, 0);

        // Randomized instructions with random pending delays and backpressure
        for (int t = 0; t < 40; t++) begin
            prep(OP_W'($urandom), REG_W'($urandom_range(0, 31)), REG_W'($urandom_range(0, 31)),
                 REG_W'($urandom_range(0, 31)), $urandom, $urandom,
                 int'($urandom_range(0, 5)) - 1, int'($urandom_range(0, 5)) - 1,
                 $urandom, $urandom);
            do_accept(); wait_phase(); fire_phase(int'($urandom_range(0, 3)));
        end

        // Reset in ISSUE with out_ready high: no mark, everything cleared
        prep(8'h5A, 5'd15, 5'd16, 5'd17, 32'hF, 32'h10, -1, -1, '0, '0);
        do_accept(); wait_phase();
        void'(exp_q.pop_front());
        out_ready = 1'b1; rst = 1'b1;
        #1;
        chk("rst_mid_rf_rd", rf_rd, 0);
        tick();
        rst = 1'b0; out_ready = 1'b0;
        stall_exp = 0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_stall_cnt", stall_cnt, stall_exp);
        chk("rst_mid_rf_rs1", rf_rs1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
